sqrt_share_arbiter: RTL
=======================

Name: sqrt_share_arbiter

Overview:
- Shares one iterative integer square-root core between NREQ requesters, such as the side-length and Heron-term stages of the geofence datapath.
- Uses round-robin arbitration and a valid/ready handshake on both sides.
- Accepts one radicand at a time and computes one root bit per cycle.
- Returns the root tagged with the requester index.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IN_W, 20, radicand width; must equal 2*OUT_W.
- OUT_W, 10, root width; also the number of iteration cycles.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_data  input  NREQ*IN_W  unsigned radicands; requester i uses bits [i*IN_W +: IN_W].
- req_ready  output  NREQ  one-hot grant/accept; at most one bit high.
- rsp_valid  output  1  result valid.
- rsp_id  output  clog2(NREQ)  index of the requester that owns the result.
- rsp_root  output  OUT_W  floor(sqrt(radicand)), or the rounded root when the optional feature is enabled.
- rsp_ready  input  1  consumer accepts the result.

Behaviour:
- Reset is synchronous and active-high, sampled on the clk edge. It forces:
  - state IDLE;
  - rsp_valid=0, rsp_id=0, rsp_root=0, req_ready=0;
  - rr_ptr=NREQ-1, so requester 0 wins first;
  - internal rem, root and iteration counter to 0.
- Reset asserted mid-operation aborts the calculation with no response. The aborted requester has already been accepted and is not re-served.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - Winner = first requester with req_valid set, searching from rr_ptr+1 and wrapping modulo NREQ.
  - req_ready[winner]=1 combinationally. req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
  - On the edge where valid&&ready: latch data and id, set rr_ptr=winner, root=0, rem=0, cnt=OUT_W-1, go to CALC.
  - With no valid request, stay in IDLE and leave rr_ptr unchanged.
- CALC:
  - req_ready=0.
  - Each edge consumes the two MSBs of the shifted radicand:
    - rem' = (rem<<2)|msb2;
    - trial = (root<<2)|1;
    - if rem' >= trial then rem = rem' - trial and root = (root<<1)|1;
    - else rem = rem' and root = root<<1.
  - rem is OUT_W+2 bits wide, which cannot overflow for IN_W=2*OUT_W.
  - On the edge with cnt==0, go to RESP.
  - Latency: acceptance at edge k gives rsp_valid=1 after edge k+OUT_W.
- RESP:
  - rsp_valid=1; rsp_id and rsp_root stay stable until the handshake.
  - On the edge with rsp_ready=1, clear rsp_valid and go to IDLE.
  - No new request is accepted in the same cycle.
  - Steady-state throughput is one result per OUT_W+2 cycles when rsp_ready is tied high.
- Requesters must hold req_valid and req_data stable until accepted. A requester that drops req_valid before acceptance simply loses its turn.
- Radicand 0 returns root 0. The maximum radicand 2^IN_W-1 returns 2^OUT_W-1.
- Simultaneous requests are resolved purely by rr_ptr. No requester is served twice while another has been waiting continuously.

Optional Feature:
- SQRT_ARB_ROUND_EN defined: in RESP, if the final rem > root then rsp_root = root+1, saturated at 2^OUT_W-1; otherwise rsp_root = root. This gives round-to-nearest. Latency is unchanged.
- Not defined: rsp_root is floor(sqrt(radicand)).

Decomposition:
- Shared package geofence_pkg holds:
  - FSM state encodings (ST_IDLE, ST_CALC, ST_RESP);
  - default widths SQRT_IN_W=20 and SQRT_OUT_W=10;
  - the NREQ limit.
- Sub-module sqrt_iter_core holds the rem/root registers, the per-cycle iteration step, and start/done signals.
- The arbiter itself holds the FSM, round-robin pointer, response registers and rounding.

Test Plan:
- Reset, then only req0 valid with data=400 -> req_ready=0001 the same cycle; rsp_valid 10 cycles after acceptance; rsp_id=0, rsp_root=20.
- Boundary values on req2: data=0 -> root 0; data=1048575 -> root 1023 (rounded build: rem 2046>1023, saturates at 1023).
- All four req_valid held continuously with data 16/81/144/225 -> grants in order 0,1,2,3,0; roots 4/9/12/15 with matching rsp_id.
- rsp_ready low for 5 cycles after rsp_valid -> rsp_valid, rsp_id and rsp_root stable; no req_ready while waiting; IDLE one cycle after rsp_ready.
- Reset asserted at the 5th CALC cycle of req1 -> next cycle rsp_valid=0, req_ready=0; then req1 and req3 valid -> req0 has priority slot but is idle, so req1 is granted first again.
- Rounding with data=30 and data=31 -> floor build gives 5 and 5; SQRT_ARB_ROUND_EN build gives 5 and 6.

Source files
------------

// File: rtl/geofence_pkg.sv
// Shared types and default widths for the geofence square-root datapath.
// Latency: none (declarations only).
// Backpressure: n/a.
package geofence_pkg;

    // Default radicand/root widths; the radicand is always twice the root width.
    localparam int SQRT_IN_W  = 20;
    localparam int SQRT_OUT_W = 10;

    // Supported range of requesters sharing one root core.
    localparam int SQRT_NREQ_MIN = 2;
    localparam int SQRT_NREQ_MAX = 8;

    // Arbiter control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } sqrt_state_t;

endpackage

// File: rtl/sqrt_iter_core.sv
// Digit-by-digit integer square root, one root bit per cycle.
// Latency: OUT_W cycles from start_i to the edge where done_o is high.
// Backpressure: none; start_i is only honoured by the owner while the core is idle.
module sqrt_iter_core
    import geofence_pkg::*;
#(
    parameter int IN_W  = SQRT_IN_W,
    parameter int OUT_W = SQRT_OUT_W
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [IN_W-1:0]  radicand_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [OUT_W-1:0] root_nxt_o,
    output logic [OUT_W+1:0] rem_nxt_o
);

    localparam int CNT_W = $clog2(OUT_W + 1);

    logic [IN_W-1:0]  rad_q;
    logic [OUT_W+1:0] rem_q;
    logic [OUT_W-1:0] root_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    logic [OUT_W+1:0] rem_sh;
    logic [OUT_W+1:0] trial;
    logic [OUT_W+1:0] rem_d;
    logic [OUT_W-1:0] root_d;

    // One restoring step: bring down two radicand bits, try to append a 1 to the root.
    // Before the last step rem < 2^OUT_W, so dropping its top two bits on the shift is lossless.
    always_comb begin
        rem_sh = {rem_q[OUT_W-1:0], rad_q[IN_W-1 -: 2]};
        trial  = {root_q, 2'b01};
        rem_d  = rem_sh;
        root_d = {root_q[OUT_W-2:0], 1'b0};
        if (rem_sh >= trial) begin
            rem_d  = rem_sh - trial;
            root_d = {root_q[OUT_W-2:0], 1'b1};
        end
    end

    // Load a new radicand on start, otherwise iterate while busy and stop after the last bit.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            rad_q  <= radicand_i;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= CNT_W'(OUT_W - 1);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rad_q  <= rad_q << 2;
            rem_q  <= rem_d;
            root_q <= root_d;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = busy_q && (cnt_q == '0);
    assign root_nxt_o = root_d;
    assign rem_nxt_o  = rem_d;

endmodule

// File: rtl/sqrt_share_arbiter.sv
// Round-robin share of one iterative square-root core between NREQ requesters;
// optional round-to-nearest result under macro SQRT_ARB_ROUND_EN.
// Latency: accept at edge k -> rsp_valid after edge k+OUT_W; backpressure: rsp_ready low holds the result, no new grants until it is taken.
module sqrt_share_arbiter
    import geofence_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IN_W  = SQRT_IN_W,
    parameter int OUT_W = SQRT_OUT_W,
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*IN_W-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [OUT_W-1:0]     rsp_root,
    input  logic                 rsp_ready
);

    sqrt_state_t      state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  rsp_id_q;
    logic [OUT_W-1:0] rsp_root_q;

    logic [ID_W-1:0]  win;
    logic [ID_W-1:0]  idx;
    logic             win_found;
    logic             accept;

    logic             core_busy;
    logic             core_done;
    logic [OUT_W-1:0] core_root;
    logic [OUT_W+1:0] core_rem;
    logic [OUT_W-1:0] root_fin;

    // Round-robin search: first valid requester after the last winner, wrapping.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = ID_W'((int'(rr_ptr_q) + k) % NREQ);
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win       = idx;
            end
        end
    end

    // Next-state and handshake outputs; grants are suppressed while reset is held.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        req_ready = '0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!reset && win_found) begin
                    req_ready[win] = 1'b1;
                    accept         = 1'b1;
                    rr_ptr_d       = win;
                    state_d        = ST_CALC;
                end
            end
            ST_CALC: begin
                if (core_done) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    sqrt_iter_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (accept),
        .radicand_i (req_data[int'(win)*IN_W +: IN_W]),
        .busy_o     (core_busy),
        .done_o     (core_done),
        .root_nxt_o (core_root),
        .rem_nxt_o  (core_rem)
    );

`ifdef SQRT_ARB_ROUND_EN
    logic busy_unused;
    assign busy_unused = core_busy;

    // Round to nearest: a remainder above the root means the true root is past root+0.5.
    always_comb begin
        root_fin = core_root;
        if ((core_rem > {2'b00, core_root}) && (core_root != '1)) begin
            root_fin = core_root + 1'b1;
        end
    end
`else
    // The final remainder only matters for rounding; floor root is the core result as-is.
    logic rem_unused;
    assign rem_unused = (^core_rem) ^ core_busy;

    always_comb begin
        root_fin = core_root;
    end
`endif

    // State, pointer and response registers; result is captured on the core's final step.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= ID_W'(NREQ - 1);
            rsp_id_q   <= '0;
            rsp_root_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            if (accept) begin
                rsp_id_q <= win;
            end
            if (core_done) begin
                rsp_root_q <= root_fin;
            end
        end
    end

    assign rsp_id   = rsp_id_q;
    assign rsp_root = rsp_root_q;

endmodule
